// File: rtl/mem_responder_if.sv
// ---------------------------------------------------------------------------
// mem_responder_if
// Request/response bundle between the data cache controller (master) and the
// main-memory responder (slave).
//
// Signals:
//   req_valid  master->slave  request presented
//   req_ready  slave->master  responder can accept a request
//   req_write  master->slave  1 = write word, 0 = read word
//   req_addr   master->slave  byte address (bits [1:0] select nothing)
//   req_wdata  master->slave  big-endian write word
//   resp_valid slave->master  response available
//   resp_ready master->slave  response consumed
//   resp_rdata slave->master  read data or write echo
//   resp_err   slave->master  bad address flag (only with MEM_RESPONDER_ERR_EN)
//
// Optional feature macro: MEM_RESPONDER_ERR_EN adds resp_err.
// ---------------------------------------------------------------------------
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
`ifdef MEM_RESPONDER_ERR_EN
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
`else
    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata
    );
`endif
endinterface

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Terminal main memory behind the data cache. Serves single-word reads and
// writes from a big-endian, byte-addressed store of 2**ADDR_BITS bytes with a
// fixed access latency.
//
// Parameters:
//   ADDR_BITS  byte-address width of the store (default 12 -> 4096 bytes)
//   LATENCY    edges from request acceptance to resp_valid (1..15)
//
// Ports:
//   clock  single clock, all logic on posedge
//   reset  synchronous active-low reset
//   bus    mem_responder_if.slave (request and response channels)
//
// Optional feature macro: MEM_RESPONDER_ERR_EN
//   When defined, out-of-range or misaligned addresses raise resp_err, reads
//   return 0 and writes leave the store untouched. When undefined, upper
//   address bits alias and bits [1:0] are ignored.
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int ADDR_BITS = 12,
    parameter int LATENCY   = 3
) (
    input  logic           clock,
    input  logic           reset,
    mem_responder_if.slave bus
);

    localparam int          WORDS     = 2 ** (ADDR_BITS - 2);
    localparam logic [3:0]  LOAD      = 4'(LATENCY - 1);
    localparam logic [31:0] ADDR_MASK = 32'((64'd1 << ADDR_BITS) - 64'd1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                 r_state;
    state_t                 w_nextState;
    logic                   w_accept;
    logic                   w_enterResp;
    logic                   w_respDone;
    logic                   w_reqErr;
    logic                   w_errHit;

    logic                   r_reqReady;
    logic                   r_respValid;
    logic [31:0]            r_respRdata;
    logic [3:0]             r_count;
    logic [ADDR_BITS-3:0]   r_wordIdx;
    logic                   r_write;
    logic [31:0]            r_wdata;

    // Word-wide store; bits [31:24] of each word are the lowest byte address,
    // so word-granular access gives the big-endian byte layout directly.
    // Contents survive reset; only power-up establishes the initial image.
    logic [31:0] r_mem [WORDS] = '{
        0:       32'h0000_0004,
        1:       32'h0000_0003,
        2:       32'h0000_0002,
        3:       32'h0000_0001,
        default: 32'h0000_0000
    };

    // Address outside the store or not word aligned.
    assign w_reqErr = (|(bus.req_addr & ~ADDR_MASK)) | (|bus.req_addr[1:0]);

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. The counter holds the number of WAIT edges still to
    // pass; the edge that finds it at zero is the one that enters RESP, which
    // places resp_valid exactly LATENCY edges after acceptance.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_enterResp = 1'b0;
        w_respDone  = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_reqReady && bus.req_valid) begin
                    w_accept    = 1'b1;
                    w_nextState = WAIT;
                end
            end
            WAIT: begin
                if (r_count == 4'd0) begin
                    w_enterResp = 1'b1;
                    w_nextState = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    w_respDone  = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Request capture, latency countdown and response registers. req_ready is
    // registered so it stays low through the reset cycle and rises on the
    // first edge after release.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_reqReady  <= 1'b0;
            r_respValid <= 1'b0;
            r_respRdata <= 32'h0;
            r_count     <= 4'd0;
        end else begin
            r_reqReady <= (w_nextState == IDLE);
            if (w_accept) begin
                r_wordIdx <= bus.req_addr[ADDR_BITS-1:2];
                r_write   <= bus.req_write;
                r_wdata   <= bus.req_wdata;
                r_count   <= LOAD;
            end else if (r_state == WAIT && r_count != 4'd0) begin
                r_count <= r_count - 4'd1;
            end
            if (w_enterResp) begin
                r_respValid <= 1'b1;
                if (w_errHit) begin
                    r_respRdata <= 32'h0;
                end else if (r_write) begin
                    r_respRdata <= r_wdata;
                end else begin
                    r_respRdata <= r_mem[r_wordIdx];
                end
            end else if (w_respDone) begin
                r_respValid <= 1'b0;
            end
        end
    end

    // Store write port: a write commits on the edge that enters RESP, so a
    // following read sees it, and a reset while waiting drops it.
    always_ff @(posedge clock) begin
        if (reset && w_enterResp && r_write && !w_errHit) begin
            r_mem[r_wordIdx] <= r_wdata;
        end
    end

`ifdef MEM_RESPONDER_ERR_EN
    logic r_err;
    logic r_respErr;

    // Error flag is decided at acceptance and presented alongside resp_valid.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_err     <= 1'b0;
            r_respErr <= 1'b0;
        end else begin
            if (w_accept) begin
                r_err <= w_reqErr;
            end
            if (w_enterResp) begin
                r_respErr <= r_err;
            end else if (w_respDone) begin
                r_respErr <= 1'b0;
            end
        end
    end

    assign w_errHit     = r_err;
    assign bus.resp_err = r_respErr;
`else
    logic w_unusedAddrBits;

    assign w_errHit         = 1'b0;
    assign w_unusedAddrBits = w_reqErr;
`endif

    assign bus.req_ready  = r_reqReady;
    assign bus.resp_valid = r_respValid;
    assign bus.resp_rdata = r_respRdata;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
// Self-checking bench for mem_responder. A byte-level big-endian model of the
// store predicts every response; directed cases cover reset, aliasing,
// response hold, reset during WAIT/RESP, and random traffic follows.
// Optional feature macro: MEM_RESPONDER_ERR_EN (also checks resp_err).
// ---------------------------------------------------------------------------
module tb_mem_responder;

    localparam int AB        = 12;
    localparam int LAT       = 3;
    localparam int MEM_BYTES = 1 << AB;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    logic [7:0] refMem [MEM_BYTES];

    mem_responder_if memBus();

    mem_responder #(
        .ADDR_BITS (AB),
        .LATENCY   (LAT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (memBus)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop in case a handshake never completes.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit modelErr(input logic [31:0] addr);
`ifdef MEM_RESPONDER_ERR_EN
        return (addr >= 32'(MEM_BYTES)) || (addr[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] addr);
        int a;
        a = int'(addr % 32'(MEM_BYTES)) / 4 * 4;
        return {refMem[a], refMem[a+1], refMem[a+2], refMem[a+3]};
    endfunction

    // Predict the response of one transaction and apply its effect.
    task automatic modelTxn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] expData, output logic expErr);
        int a;
        expErr = modelErr(addr);
        if (expErr) begin
            expData = 32'h0;
        end else if (wr) begin
            a = int'(addr % 32'(MEM_BYTES)) / 4 * 4;
            refMem[a]   = wdata[31:24];
            refMem[a+1] = wdata[23:16];
            refMem[a+2] = wdata[15:8];
            refMem[a+3] = wdata[7:0];
            expData = wdata;
        end else begin
            expData = modelRead(addr);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a request and wait (bounded) for its acceptance edge.
    task automatic issueRequest(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        int waitCnt;
        memBus.req_valid = 1'b1;
        memBus.req_write = wr;
        memBus.req_addr  = addr;
        memBus.req_wdata = wdata;
        waitCnt = 0;
        while (memBus.req_ready !== 1'b1 && waitCnt < 20) begin
            tick();
            waitCnt++;
        end
        checkOutput("acceptTimeout", 32'(waitCnt >= 20), 32'd0);
        tick();
        memBus.req_valid = 1'b0;
        memBus.req_addr  = $urandom;
        memBus.req_wdata = $urandom;
    endtask

    // Full transaction: request, latency check, optional response hold with a
    // stray request pulse, then handshake.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input int hold);
        logic [31:0] expData;
        logic        expErr;
        modelTxn(wr, addr, wdata, expData, expErr);
        issueRequest(wr, addr, wdata);
        for (int k = 0; k < LAT; k++) begin
            checkOutput("earlyValid", 32'(memBus.resp_valid), 32'd0);
            checkOutput("busyReady", 32'(memBus.req_ready), 32'd0);
            tick();
        end
        checkOutput("respValid", 32'(memBus.resp_valid), 32'd1);
        checkOutput("respData", memBus.resp_rdata, expData);
`ifdef MEM_RESPONDER_ERR_EN
        checkOutput("respErr", 32'(memBus.resp_err), 32'(expErr));
`endif
        checkOutput("respReady", 32'(memBus.req_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            if (h == 1) begin
                memBus.req_valid = 1'b1;
                memBus.req_write = 1'b1;
            end
            tick();
            memBus.req_valid = 1'b0;
            checkOutput("holdValid", 32'(memBus.resp_valid), 32'd1);
            checkOutput("holdData", memBus.resp_rdata, expData);
        end
        memBus.resp_ready = 1'b1;
        tick();
        memBus.resp_ready = 1'b0;
        checkOutput("doneValid", 32'(memBus.resp_valid), 32'd0);
        checkOutput("doneReady", 32'(memBus.req_ready), 32'd1);
    endtask

    task automatic releaseReset();
        checkOutput("rstReady", 32'(memBus.req_ready), 32'd0);
        checkOutput("rstValid", 32'(memBus.resp_valid), 32'd0);
        checkOutput("rstData", memBus.resp_rdata, 32'd0);
        reset = 1'b1;
        tick();
        checkOutput("postRstReady", 32'(memBus.req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] expData;
        logic        expErr;
        logic [31:0] addr;

        total = 0;
        bad   = 0;
        for (int i = 0; i < MEM_BYTES; i++) begin
            refMem[i] = 8'h00;
        end
        refMem[3]  = 8'h04;
        refMem[7]  = 8'h03;
        refMem[11] = 8'h02;
        refMem[15] = 8'h01;

        memBus.req_valid  = 1'b0;
        memBus.req_write  = 1'b0;
        memBus.req_addr   = 32'h0;
        memBus.req_wdata  = 32'h0;
        memBus.resp_ready = 1'b0;
        reset = 1'b0;

        // Reset held low for two edges.
        tick();
        tick();
        releaseReset();

        // Power-up image, write/read with aliasing, held response.
        applyStimulus(1'b0, 32'h0000_0000, 32'h0, 0);
        applyStimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
        applyStimulus(1'b0, 32'h0000_0010, 32'h0, 0);
        applyStimulus(1'b0, 32'h0000_1010, 32'h0, 0);
        applyStimulus(1'b0, 32'h0000_000C, 32'h0, 5);

        // Reset while waiting: the write must never reach the store.
        issueRequest(1'b1, 32'h0000_0020, 32'h1234_5678);
        reset = 1'b0;
        tick();
        tick();
        releaseReset();
        applyStimulus(1'b0, 32'h0000_0020, 32'h0, 0);

        // Reset while responding: the write already landed.
        modelTxn(1'b1, 32'h0000_0030, 32'hCAFE_F00D, expData, expErr);
        issueRequest(1'b1, 32'h0000_0030, 32'hCAFE_F00D);
        for (int k = 0; k < LAT; k++) begin
            tick();
        end
        checkOutput("rspRstValid", 32'(memBus.resp_valid), 32'd1);
        checkOutput("rspRstData", memBus.resp_rdata, expData);
        reset = 1'b0;
        tick();
        releaseReset();
        applyStimulus(1'b0, 32'h0000_0030, 32'h0, 0);

        // Bad-address traffic (errors with the feature, aliasing without).
        applyStimulus(1'b1, 32'h0000_2002, 32'hAAAA_AAAA, 0);
        applyStimulus(1'b0, 32'h0000_1000, 32'h0, 0);
        applyStimulus(1'b0, 32'h0000_0000, 32'h0, 0);
        applyStimulus(1'b0, 32'h0000_0002, 32'h0, 0);

        // Random traffic over a small window so reads hit earlier writes.
        for (int n = 0; n < 40; n++) begin
            addr = 32'($urandom_range(0, 15)) * 32'd4;
            if ($urandom_range(0, 5) == 0) begin
                addr = addr | (32'($urandom_range(1, 3)) << AB);
            end
            if ($urandom_range(0, 7) == 0) begin
                addr = addr | 32'($urandom_range(1, 3));
            end
            applyStimulus(1'($urandom_range(0, 1)), addr, $urandom, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
